// File: rtl/sodor_mem_responder.sv
// Single-port memory responder for the Sodor imem/dmem request interface.
// One request in flight; byte/half/word access with a fixed response latency.
//
// state | meaning
// IDLE  | ready for a request, no response pending
// WAIT  | request accepted, counting down to its response
// RESP  | response pulse this cycle; a new request may be accepted
module sodor_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [31:0] io_req_bits_addr,
  input  logic [31:0] io_req_bits_data,
  input  logic        io_req_bits_fcn,
  input  logic [2:0]  io_req_bits_typ,
  output logic        io_resp_valid,
  output logic [31:0] io_resp_bits_data,
  output logic        io_resp_bits_err,
  output logic        io_busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [31:0]   pend_data;
  logic          pend_err;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          is_byte;
  logic          is_half;
  logic          is_word;
  logic          req_err;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   rd_ext;
  logic [31:0]   rsp_next;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic          wr_en;

  assign io_req_ready      = (state != ST_WAIT);
  assign io_resp_valid     = (state == ST_RESP);
  assign io_busy           = (state == ST_WAIT);
  assign io_resp_bits_data = resp_data;
  assign io_resp_bits_err  = resp_err;

  assign accept   = io_req_valid && io_req_ready;
  assign word_idx = io_req_bits_addr[AW+1:2];
  assign rd_word  = mem[word_idx];

  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    case (io_req_bits_typ)
      MT_B, MT_BU: is_byte = 1'b1;
      MT_H, MT_HU: is_half = 1'b1;
      MT_W:        is_word = 1'b1;
      default:     ;
    endcase
    req_err = !(is_byte || is_half || is_word)
            || (is_half && io_req_bits_addr[0])
            || (is_word && (io_req_bits_addr[1:0] != 2'b00))
            || (io_req_bits_addr >= ADDR_LIMIT);
  end

  always_comb begin
    rd_byte = 8'h00;
    case (io_req_bits_addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = io_req_bits_addr[1] ? rd_word[31:16] : rd_word[15:0];
    rd_ext  = 32'h0;
    case (io_req_bits_typ)
      MT_B:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
      MT_BU:   rd_ext = {24'h0, rd_byte};
      MT_H:    rd_ext = {{16{rd_half[15]}}, rd_half};
      MT_HU:   rd_ext = {16'h0, rd_half};
      MT_W:    rd_ext = rd_word;
      default: rd_ext = 32'h0;
    endcase
    rsp_next = (req_err || io_req_bits_fcn) ? 32'h0 : rd_ext;
  end

  // Write data is replicated across lanes so the byte enables alone pick the target lane.
  always_comb begin
    wr_be   = 4'b1111;
    wr_data = io_req_bits_data;
    if (is_byte) begin
      wr_be   = 4'b0001 << io_req_bits_addr[1:0];
      wr_data = {4{io_req_bits_data[7:0]}};
    end else if (is_half) begin
      wr_be   = io_req_bits_addr[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{io_req_bits_data[15:0]}};
    end
    wr_en = accept && io_req_bits_fcn && !req_err;
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // The visible response registers only change when a response issues, so the
  // result of an accepted request waits in pend_* while the previous one is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      pend_data <= 32'h0;
      pend_err  <= 1'b0;
      resp_data <= 32'h0;
      resp_err  <= 1'b0;
    end else if (accept) begin
      pend_data <= rsp_next;
      pend_err  <= req_err;
      if (LATENCY == 1) begin
        state     <= ST_RESP;
        resp_data <= rsp_next;
        resp_err  <= req_err;
      end else begin
        state <= ST_WAIT;
        cnt   <= LAT_M1;
      end
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            state     <= ST_RESP;
            cnt       <= 4'd0;
            resp_data <= pend_data;
            resp_err  <= pend_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sodor_mem_responder.md
# sodor_mem_responder

Single-port memory responder that terminates the Sodor core's memory request interface (the imem/dmem request/response pair the core initiates). It accepts one request at a time over a valid/ready handshake, performs a byte/half/word read or write against an internal word-addressed array, and returns a one-cycle response pulse a fixed `LATENCY` cycles later. It sits outside the core next to the datapath, one instance per memory port.

## Interface
- `DEPTH_WORDS`, 1024: array size in 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- `LATENCY`, 2: cycles from request acceptance to the response pulse; legal range 1..15.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `io_req_valid`  in  1  request present.
- `io_req_ready`  out  1  responder can accept a request this cycle.
- `io_req_bits_addr`  in  32  byte address.
- `io_req_bits_data`  in  32  write data, right-aligned.
- `io_req_bits_fcn`  in  1  0 = M_XRD (read), 1 = M_XWR (write).
- `io_req_bits_typ`  in  3  1 = MT_B, 2 = MT_H, 3 = MT_W, 5 = MT_BU, 6 = MT_HU; 0, 4 and 7 are illegal.
- `io_resp_valid`  out  1  one-cycle response pulse.
- `io_resp_bits_data`  out  32  read data, extended to 32 bits; 0 for writes and errors.
- `io_resp_bits_err`  out  1  request was rejected (misaligned, out of range, or illegal typ).
- `io_busy`  out  1  a request is accepted and its response is not yet issued.

## Operation
- A request is accepted on a rising edge where `io_req_valid && io_req_ready`.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: ready=1, resp_valid=0. On accept, go to RESP if LATENCY=1, otherwise go to WAIT with the counter loaded to LATENCY-1.
  - WAIT: ready=0, resp_valid=0, busy=1. The counter decrements each cycle; at 1, go to RESP.
  - RESP: ready=1, resp_valid=1. A new accept in this cycle goes to WAIT or RESP by the same rule as IDLE; otherwise go to IDLE.
- Error checks, evaluated at accept:
  - Illegal typ.
  - MT_H/MT_HU with addr[0]=1.
  - MT_W with addr[1:0]≠0.
  - addr ≥ 4*DEPTH_WORDS.
  - On error: no array write, response data 0, err=1.
- Read: the word at addr[31:2] is sampled at the accept edge.
  - Byte lane is addr[1:0]; half lane is addr[1].
  - MT_B and MT_H are sign-extended; MT_BU and MT_HU are zero-extended; MT_W is the raw word.
  - The result is held in the response register until the response is issued.
- Write: committed at the accept edge.
  - MT_B writes data[7:0] into lane addr[1:0].
  - MT_H writes data[15:0] into lane addr[1].
  - MT_W writes the full word.
  - Unwritten lanes are preserved.
  - The response still pulses, with data 0 and err 0.
  - MT_BU and MT_HU writes behave as MT_B and MT_H.
- Reads never see partial effects of their own request. A later write cannot alter an already-sampled read result.
- `io_resp_bits_data` and `io_resp_bits_err` hold their last values outside the pulse.

## Timing
- Reset values:
  - io_req_ready=1 (state IDLE).
  - io_resp_valid=0, io_resp_bits_data=0, io_resp_bits_err=0, io_busy=0.
  - Counter 0.
  - The array is not reset; contents are undefined until written.
- Request accepted at edge T: resp_valid is high during cycle T+LATENCY only. ready is low during cycles T+1 .. T+LATENCY-1.
- Back-to-back: a request accepted in the RESP cycle yields its response exactly LATENCY cycles later. Sustained throughput is one request per LATENCY cycles.
- With LATENCY=1, ready stays 1 and one request/response completes per cycle.
- Request inputs are only sampled at accept; valid held while ready=0 has no effect.
- Reset asserted mid-operation:
  - State goes to IDLE immediately and any pending response is dropped.
  - A write accepted before reset stays committed.

## Test plan
- Word write/read, LATENCY=2: write 0xDEADBEEF to 0x10 (MT_W) accepted at T → resp_valid at T+2 with data 0 and err 0; read 0x10 → data 0xDEADBEEF.
- Sub-word: after the word above, MT_B write 0x80 to 0x11 → word = 0xDEAD80EF. MT_B read 0x11 → 0xFFFFFF80. MT_BU read 0x11 → 0x00000080. MT_HU read 0x12 → 0x0000DEAD. MT_H read 0x12 → 0xFFFFDEAD.
- Errors: MT_W read at 0x2 → err=1, data 0. MT_H write at 0x13 → err=1 and word 0x10 unchanged. typ=4 → err=1. addr 0x1000 with DEPTH_WORDS=1024 → err=1.
- Handshake: valid held high continuously with LATENCY=3 → accepts at T, T+3, T+6; resp pulses at T+3, T+6, T+9; ready low exactly at T+1 and T+2. LATENCY=1 → one response per cycle.
- Async reset: assert reset in the WAIT cycle after a read is accepted → resp_valid, busy and err go 0 without a clock edge, ready goes 1, and no response appears after deassert.
